// File: rtl/branch_predict_ctrl_if.sv
// Bundle between the branch predictor/recovery controller and the pipeline:
// fetch-side prediction lookup, EX-side resolution, redirect/flush and counters.
interface branch_predict_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      if_pc;
    logic             pred_taken;
    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic             ex_taken;
    logic             ex_pred_taken;
    logic [31:0]      ex_target;
    logic             stall;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             flush;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    // Pipeline side: supplies fetch PC and resolved branches
    modport master (
        output if_pc, ex_valid, ex_pc, ex_taken, ex_pred_taken, ex_target, stall,
        input  pred_taken, redirect, redirect_pc, flush, branch_cnt, mispredict_cnt
    );

    // Controller side
    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_taken, ex_pred_taken, ex_target, stall,
        output pred_taken, redirect, redirect_pc, flush, branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Branch prediction and recovery controller: direct-mapped 2-bit saturating
// counter table read at fetch, trained at EX; on a mispredict it redirects the
// PC and holds flush for the mispredict cycle plus FLUSH_EXTRA further cycles.
module branch_predict_ctrl #(
    parameter int unsigned IDX_BITS    = 4,
    parameter int unsigned FLUSH_EXTRA = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    branch_predict_ctrl_if.slave bus
);
    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t               state;
    logic [2:0]           flush_cnt;
    logic [1:0]           ctr [ENTRIES];
    logic [IDX_BITS-1:0]  if_idx;
    logic [IDX_BITS-1:0]  ex_idx;
    logic                 accept;
    logic                 mispredict;
    logic [CNT_W-1:0]     branch_q;
    logic [CNT_W-1:0]     mispred_q;
    logic                 unused_pc_bits;

    // Table indexing, resolution qualifiers and combinational redirect/flush
    always_comb begin
        if_idx          = bus.if_pc[IDX_BITS+1:2];
        ex_idx          = bus.ex_pc[IDX_BITS+1:2];
        accept          = bus.ex_valid & ~bus.stall & (state == IDLE);
        mispredict      = accept & (bus.ex_taken != bus.ex_pred_taken);
        bus.pred_taken  = ctr[if_idx][1];
        bus.redirect    = mispredict;
        bus.redirect_pc = '0;
        if (mispredict) begin
            bus.redirect_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
        end
        bus.flush          = mispredict | (state == FLUSH);
        bus.branch_cnt     = branch_q;
        bus.mispredict_cnt = mispred_q;
    end

    assign unused_pc_bits = ^{bus.if_pc[31:IDX_BITS+2], bus.if_pc[1:0]};

    // Counter table training on each accepted branch (no same-cycle bypass)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr[i] <= 2'b01;
            end
        end else if (accept) begin
            if (bus.ex_taken) begin
                if (ctr[ex_idx] != 2'b11) ctr[ex_idx] <= ctr[ex_idx] + 2'd1;
            end else begin
                if (ctr[ex_idx] != 2'b00) ctr[ex_idx] <= ctr[ex_idx] - 2'd1;
            end
        end
    end

    // Flush sequencer: extra flush cycles count down only on non-stalled cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mispredict && (FLUSH_EXTRA != 0)) begin
                        state     <= FLUSH;
                        flush_cnt <= 3'(FLUSH_EXTRA);
                    end
                end
                FLUSH: begin
                    if (!bus.stall) begin
                        if (flush_cnt == 3'd1) state <= IDLE;
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    flush_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_q  <= '0;
            mispred_q <= '0;
        end else if (accept) begin
            if (branch_q != '1) branch_q <= branch_q + 1'b1;
            if (mispredict && (mispred_q != '1)) mispred_q <= mispred_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: the stimulus process pushes
// hand-computed expectations each cycle, a monitor pops and compares them at
// the falling edge. Instance A uses FLUSH_EXTRA=0, instance B FLUSH_EXTRA=2.
module tb_branch_predict_ctrl;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    branch_predict_ctrl_if #(.CNT_W(16)) ifa ();
    branch_predict_ctrl_if #(.CNT_W(16)) ifb ();

    branch_predict_ctrl #(.IDX_BITS(4), .FLUSH_EXTRA(0), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa.slave)
    );

    branch_predict_ctrl #(.IDX_BITS(4), .FLUSH_EXTRA(2), .CNT_W(16)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb.slave)
    );

    localparam int unsigned P_PRED  = 0;
    localparam int unsigned P_REDIR = 1;
    localparam int unsigned P_RPC   = 2;
    localparam int unsigned P_FLUSH = 3;
    localparam int unsigned P_BCNT  = 4;
    localparam int unsigned P_MCNT  = 5;
    localparam int unsigned B       = 6;

    typedef struct {
        string       name;
        int unsigned sel;
        logic [31:0] exp;
    } chk_t;

    chk_t        sbq[$];
    int unsigned total = 0;
    int unsigned bad   = 0;

    function automatic logic [31:0] probe(int unsigned sel);
        case (sel)
            P_PRED:      return {31'b0, ifa.pred_taken};
            P_REDIR:     return {31'b0, ifa.redirect};
            P_RPC:       return ifa.redirect_pc;
            P_FLUSH:     return {31'b0, ifa.flush};
            P_BCNT:      return {16'b0, ifa.branch_cnt};
            P_MCNT:      return {16'b0, ifa.mispredict_cnt};
            B + P_PRED:  return {31'b0, ifb.pred_taken};
            B + P_REDIR: return {31'b0, ifb.redirect};
            B + P_RPC:   return ifb.redirect_pc;
            B + P_FLUSH: return {31'b0, ifb.flush};
            B + P_BCNT:  return {16'b0, ifb.branch_cnt};
            B + P_MCNT:  return {16'b0, ifb.mispredict_cnt};
            default:     return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic push(string name, int unsigned sel, logic [31:0] v);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = v;
        sbq.push_back(c);
    endtask

    // Monitor: compare everything queued for this cycle at the falling edge
    initial begin
        chk_t        c;
        logic [31:0] got;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                c   = sbq.pop_front();
                got = probe(c.sel);
                total++;
                if (got !== c.exp) begin
                    bad++;
                    $display("FAIL %s: got=%h want=%h at %0t", c.name, got, c.exp, $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(logic v, logic [31:0] pc, logic tk, logic pt,
                           logic [31:0] tgt, logic st);
        ifa.ex_valid      = v;
        ifa.ex_pc         = pc;
        ifa.ex_taken      = tk;
        ifa.ex_pred_taken = pt;
        ifa.ex_target     = tgt;
        ifa.stall         = st;
    endtask

    task automatic drive_b(logic v, logic [31:0] pc, logic tk, logic pt,
                           logic [31:0] tgt, logic st);
        ifb.ex_valid      = v;
        ifb.ex_pc         = pc;
        ifb.ex_taken      = tk;
        ifb.ex_pred_taken = pt;
        ifb.ex_target     = tgt;
        ifb.stall         = st;
    endtask

    // Watchdog so the run always terminates
    initial begin
        #1_500_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] walk_pred [4];
        walk_pred[0] = 32'd1;
        walk_pred[1] = 32'd1;
        walk_pred[2] = 32'd0;
        walk_pred[3] = 32'd0;

        ifa.if_pc = '0;
        ifb.if_pc = '0;
        drive_a(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        drive_b(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        step();

        // Reset state
        push("rst_redir", P_REDIR, 0);
        push("rst_rpc",   P_RPC,   0);
        push("rst_flush", P_FLUSH, 0);
        push("rst_bcnt",  P_BCNT,  0);
        push("rst_mcnt",  P_MCNT,  0);
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Prediction sweep after reset: weakly not-taken everywhere
        for (int i = 0; i < 16; i++) begin
            ifa.if_pc = 32'(i * 4);
            push("sweep_pred", P_PRED, 0);
            step();
        end

        // First mispredict: taken, predicted not-taken
        ifa.if_pc = 32'h10;
        drive_a(1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 1'b0);
        push("mp1_pred_pre", P_PRED,  0);
        push("mp1_redir",    P_REDIR, 1);
        push("mp1_rpc",      P_RPC,   32'h40);
        push("mp1_flush",    P_FLUSH, 1);
        step();

        // Update visible next cycle; train entry 2 -> 3 with a matching prediction
        drive_a(1'b1, 32'h10, 1'b1, 1'b1, 32'h40, 1'b0);
        push("mp1_pred_post", P_PRED,  1);
        push("mp1_bcnt",      P_BCNT,  1);
        push("mp1_mcnt",      P_MCNT,  1);
        push("match_redir",   P_REDIR, 0);
        push("match_flush",   P_FLUSH, 0);
        push("match_rpc",     P_RPC,   0);
        step();

        // Walk 3 -> 2 -> 1 -> 0 -> 0 with correct not-taken predictions
        for (int k = 0; k < 4; k++) begin
            drive_a(1'b1, 32'h10, 1'b0, 1'b0, 32'h40, 1'b0);
            push("walk_pred",  P_PRED,  walk_pred[k]);
            push("walk_redir", P_REDIR, 0);
            push("walk_flush", P_FLUSH, 0);
            push("walk_bcnt",  P_BCNT,  32'(2 + k));
            step();
        end

        // Entry saturated at 0; taken mispredict redirects to the target
        drive_a(1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 1'b0);
        push("sat0_pred",  P_PRED,  0);
        push("sat0_redir", P_REDIR, 1);
        push("sat0_rpc",   P_RPC,   32'h40);
        push("sat0_bcnt",  P_BCNT,  6);
        push("sat0_mcnt",  P_MCNT,  1);
        step();

        // Not-taken mispredict redirects to fall-through; 0x50 aliases 0x10
        ifa.if_pc = 32'h50;
        drive_a(1'b1, 32'h10, 1'b0, 1'b1, 32'h40, 1'b0);
        push("nt_alias_pred", P_PRED,  0);
        push("nt_redir",      P_REDIR, 1);
        push("nt_rpc",        P_RPC,   32'h14);
        push("nt_flush",      P_FLUSH, 1);
        push("nt_mcnt",       P_MCNT,  2);
        step();

        // Stalled mismatching branch: nothing happens for 3 cycles
        ifa.if_pc = 32'h20;
        for (int k = 0; k < 3; k++) begin
            drive_a(1'b1, 32'h20, 1'b1, 1'b0, 32'h80, 1'b1);
            push("stall_redir", P_REDIR, 0);
            push("stall_rpc",   P_RPC,   0);
            push("stall_flush", P_FLUSH, 0);
            push("stall_bcnt",  P_BCNT,  8);
            push("stall_mcnt",  P_MCNT,  3);
            push("stall_pred",  P_PRED,  0);
            step();
        end
        drive_a(1'b1, 32'h20, 1'b1, 1'b0, 32'h80, 1'b0);
        push("unstall_redir", P_REDIR, 1);
        push("unstall_rpc",   P_RPC,   32'h80);
        push("unstall_flush", P_FLUSH, 1);
        step();
        drive_a(1'b0, 32'h20, 1'b1, 1'b0, 32'h80, 1'b0);
        push("unstall_bcnt",  P_BCNT,  9);
        push("unstall_mcnt",  P_MCNT,  4);
        push("unstall_pred",  P_PRED,  1);
        push("idle_redir",    P_REDIR, 0);
        push("idle_flush",    P_FLUSH, 0);
        step();

        // Fall-through address wraps at 32 bits
        drive_a(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'h1234, 1'b0);
        push("wrap_redir", P_REDIR, 1);
        push("wrap_rpc",   P_RPC,   32'h2);
        step();

        // Drive branch_cnt from 10 up to all-ones with correct predictions
        for (int unsigned n = 0; n < 65525; n++) begin
            drive_a(1'b1, 32'h30, 1'b0, 1'b0, '0, 1'b0);
            step();
        end
        drive_a(1'b0, 32'h30, 1'b0, 1'b0, '0, 1'b0);
        push("full_bcnt", P_BCNT, 32'hFFFF);
        push("full_mcnt", P_MCNT, 5);
        step();
        drive_a(1'b1, 32'h30, 1'b1, 1'b0, 32'h44, 1'b0);
        push("full_redir", P_REDIR, 1);
        push("full_rpc",   P_RPC,   32'h44);
        step();
        drive_a(1'b0, 32'h30, 1'b0, 1'b0, '0, 1'b0);
        push("sat_bcnt", P_BCNT, 32'hFFFF);
        push("sat_mcnt", P_MCNT, 6);
        step();

        // Instance B: train index 2 (pc 0x08) to 3 with matching predictions
        ifb.if_pc = 32'h08;
        for (int k = 0; k < 2; k++) begin
            drive_b(1'b1, 32'h08, 1'b1, 1'b1, '0, 1'b0);
            push("b_train_redir", B + P_REDIR, 0);
            push("b_train_flush", B + P_FLUSH, 0);
            step();
        end

        // t: mispredict at pc 0x0C (not-taken, predicted taken)
        drive_b(1'b1, 32'h0C, 1'b0, 1'b1, 32'h99, 1'b0);
        push("b_t_redir", B + P_REDIR, 1);
        push("b_t_rpc",   B + P_RPC,   32'h10);
        push("b_t_flush", B + P_FLUSH, 1);
        push("b_t_pred",  B + P_PRED,  1);
        push("b_t_bcnt",  B + P_BCNT,  2);
        push("b_t_mcnt",  B + P_MCNT,  0);
        step();
        // t+1: stalled, wrong-path branch offered
        drive_b(1'b1, 32'h04, 1'b1, 1'b0, 32'h200, 1'b1);
        push("b_t1_flush", B + P_FLUSH, 1);
        push("b_t1_redir", B + P_REDIR, 0);
        push("b_t1_rpc",   B + P_RPC,   0);
        step();
        // t+2, t+3: non-stalled flush cycles, wrong-path branch ignored
        for (int k = 0; k < 2; k++) begin
            drive_b(1'b1, 32'h04, 1'b1, 1'b0, 32'h200, 1'b0);
            push("b_fl_flush", B + P_FLUSH, 1);
            push("b_fl_redir", B + P_REDIR, 0);
            push("b_fl_rpc",   B + P_RPC,   0);
            push("b_fl_bcnt",  B + P_BCNT,  3);
            push("b_fl_mcnt",  B + P_MCNT,  1);
            step();
        end
        // t+4: back in IDLE, a new mispredict is accepted
        drive_b(1'b1, 32'h04, 1'b1, 1'b0, 32'h100, 1'b0);
        push("b_t4_redir", B + P_REDIR, 1);
        push("b_t4_rpc",   B + P_RPC,   32'h100);
        push("b_t4_flush", B + P_FLUSH, 1);
        push("b_t4_bcnt",  B + P_BCNT,  3);
        step();
        // t+5: flushing again
        drive_b(1'b0, 32'h04, 1'b0, 1'b0, '0, 1'b0);
        push("b_t5_flush", B + P_FLUSH, 1);
        push("b_t5_redir", B + P_REDIR, 0);
        push("b_t5_bcnt",  B + P_BCNT,  4);
        push("b_t5_mcnt",  B + P_MCNT,  2);
        push("b_t5_pred",  B + P_PRED,  1);
        step();
        // t+6: asynchronous reset in the middle of the flush
        rst_b = 1'b1;
        push("b_rst_flush", B + P_FLUSH, 0);
        push("b_rst_redir", B + P_REDIR, 0);
        push("b_rst_bcnt",  B + P_BCNT,  0);
        push("b_rst_mcnt",  B + P_MCNT,  0);
        push("b_rst_pred",  B + P_PRED,  0);
        step();
        // Entries back to 01: idx1 reads 0, one taken update on idx2 makes it 1
        rst_b = 1'b0;
        ifb.if_pc = 32'h04;
        drive_b(1'b1, 32'h08, 1'b1, 1'b1, '0, 1'b0);
        push("b_post_pred1", B + P_PRED,  0);
        push("b_post_flush", B + P_FLUSH, 0);
        push("b_post_redir", B + P_REDIR, 0);
        step();
        ifb.if_pc = 32'h08;
        drive_b(1'b0, 32'h08, 1'b0, 1'b0, '0, 1'b0);
        push("b_post_pred2", B + P_PRED, 1);
        push("b_post_bcnt",  B + P_BCNT, 1);
        step();

        step();
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d want=0 pending checks", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
